// File: rtl/mem_stage_ctrl_pkg.sv
// Shared encodings for the memory-stage sequencer and its lane aligner.
package mem_stage_ctrl_pkg;

    localparam logic [3:0] LS_SIZE_B = 4'b0001;
    localparam logic [3:0] LS_SIZE_H = 4'b0010;
    localparam logic [3:0] LS_SIZE_W = 4'b0100;
    localparam logic [3:0] LS_SIZE_D = 4'b1000;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        DRAIN
    } ms_state_e;

    // Illegal (non one-hot) sizes are reported the same way as misalignment.
    function automatic logic ls_misaligned(input logic [3:0] size, input logic [2:0] off);
        logic bad;
        case (size)
            LS_SIZE_B: bad = 1'b0;
            LS_SIZE_H: bad = off[0];
            LS_SIZE_W: bad = |off[1:0];
            LS_SIZE_D: bad = |off;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane placement for stores and lane extract/extend for loads on an 8-byte bus.
// Pure combinational, no state and no flow control.
module mem_lane_align
    import mem_stage_ctrl_pkg::*;
(
    input  logic [3:0]  st_size_i,
    input  logic [2:0]  st_off_i,
    input  logic [63:0] st_data_i,
    output logic [63:0] st_wdata_o,
    output logic [7:0]  st_wmask_o,
    input  logic [3:0]  ld_size_i,
    input  logic [2:0]  ld_off_i,
    input  logic        ld_unsigned_i,
    input  logic [63:0] ld_rdata_i,
    output logic [63:0] ld_data_o
);

    logic [7:0]  base_mask;
    logic [63:0] sh;

    always_comb begin
        base_mask = 8'h00;
        case (st_size_i)
            LS_SIZE_B: base_mask = 8'h01;
            LS_SIZE_H: base_mask = 8'h03;
            LS_SIZE_W: base_mask = 8'h0F;
            LS_SIZE_D: base_mask = 8'hFF;
            default:   base_mask = 8'h00;
        endcase
        st_wmask_o = base_mask << st_off_i;
        st_wdata_o = st_data_i << {st_off_i, 3'b000};
    end

    always_comb begin
        sh        = ld_rdata_i >> {ld_off_i, 3'b000};
        ld_data_o = sh;
        case (ld_size_i)
            LS_SIZE_B: ld_data_o = ld_unsigned_i ? {56'd0, sh[7:0]}   : {{56{sh[7]}},  sh[7:0]};
            LS_SIZE_H: ld_data_o = ld_unsigned_i ? {48'd0, sh[15:0]}  : {{48{sh[15]}}, sh[15:0]};
            LS_SIZE_W: ld_data_o = ld_unsigned_i ? {32'd0, sh[31:0]}  : {{32{sh[31]}}, sh[31:0]};
            default:   ld_data_o = sh;
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage sequencer: one valid/ready request per load/store, stalls the EXU/MEM register until done.
// Request issued the cycle after the op is seen; responses may be flushed, drained or timed out.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  in_is_load,
    input  logic                  in_is_store,
    input  logic [3:0]            in_ls_size,
    input  logic                  in_is_unsigned,
    input  logic [ADDR_WIDTH-1:0] in_ls_address,
    input  logic [63:0]           in_store_data,
    input  logic                  flush,
    output logic                  mem_stall,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_is_write,
    output logic [63:0]           req_wdata,
    output logic [7:0]            req_wmask,
    input  logic                  resp_valid,
    input  logic [63:0]           resp_rdata,
    output logic [63:0]           load_data,
    output logic                  load_data_valid,
    output logic                  misalign,
    output logic                  bus_err
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ms_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             is_load_q;
    logic             unsigned_q;
    logic [3:0]       size_q;
    logic [2:0]       off_q;

    logic             start;
    logic             bad;
    logic             expired;
    logic [CNT_W-1:0] cnt_d;
    logic [63:0]      st_wdata;
    logic [7:0]       st_wmask;
    logic [63:0]      ld_ext;

    assign start   = in_valid & (in_is_load | in_is_store) & ~flush;
    assign bad     = ls_misaligned(in_ls_size, in_ls_address[2:0]);
    assign expired = (cnt_q == CNT_LAST);
    // Saturate so a flush on the final wait cycle still times out promptly in DRAIN.
    assign cnt_d   = expired ? cnt_q : cnt_q + 1'b1;

    assign mem_stall = ((state_q == IDLE) & start & ~bad)
                     | (state_q == REQ)
                     | (state_q == WAIT)
                     | ((state_q == DRAIN) & start);

    mem_lane_align u_lane (
        .st_size_i     (in_ls_size),
        .st_off_i      (in_ls_address[2:0]),
        .st_data_i     (in_store_data),
        .st_wdata_o    (st_wdata),
        .st_wmask_o    (st_wmask),
        .ld_size_i     (size_q),
        .ld_off_i      (off_q),
        .ld_unsigned_i (unsigned_q),
        .ld_rdata_i    (resp_rdata),
        .ld_data_o     (ld_ext)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            is_load_q       <= 1'b0;
            unsigned_q      <= 1'b0;
            size_q          <= 4'd0;
            off_q           <= 3'd0;
            req_valid       <= 1'b0;
            req_addr        <= '0;
            req_is_write    <= 1'b0;
            req_wdata       <= 64'd0;
            req_wmask       <= 8'd0;
            load_data       <= 64'd0;
            load_data_valid <= 1'b0;
            misalign        <= 1'b0;
            bus_err         <= 1'b0;
        end else begin
            load_data_valid <= 1'b0;
            misalign        <= 1'b0;
            bus_err         <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && bad) begin
                        misalign <= 1'b1;
                    end else if (start) begin
                        is_load_q    <= ~in_is_store;
                        unsigned_q   <= in_is_unsigned;
                        size_q       <= in_ls_size;
                        off_q        <= in_ls_address[2:0];
                        req_valid    <= 1'b1;
                        req_addr     <= {in_ls_address[ADDR_WIDTH-1:3], 3'b000};
                        req_is_write <= in_is_store;
                        req_wdata    <= in_is_store ? st_wdata : 64'd0;
                        req_wmask    <= in_is_store ? st_wmask : 8'd0;
                        state_q      <= REQ;
                    end
                end
                REQ: begin
                    if (flush) begin
                        req_valid <= 1'b0;
                        state_q   <= IDLE;
                    end else if (req_ready) begin
                        req_valid <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush && resp_valid) begin
                        state_q <= IDLE;
                    end else if (flush) begin
                        cnt_q   <= cnt_d;
                        state_q <= DRAIN;
                    end else if (resp_valid) begin
                        if (is_load_q) begin
                            load_data       <= ld_ext;
                            load_data_valid <= 1'b1;
                        end
                        state_q <= DONE;
                    end else if (expired) begin
                        bus_err <= 1'b1;
                        if (is_load_q) begin
                            load_data       <= 64'd0;
                            load_data_valid <= 1'b1;
                        end
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                DRAIN: begin
                    if (resp_valid) begin
                        state_q <= IDLE;
                    end else if (expired) begin
                        bus_err <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios plus randomized ops against a byte-level reference model.
module tb_mem_stage_ctrl;

    localparam int AW = 64;
    localparam int TO = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_is_load, in_is_store, in_is_unsigned, flush;
    logic [3:0]  in_ls_size;
    logic [63:0] in_ls_address, in_store_data;
    logic        mem_stall, req_valid, req_ready, req_is_write;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid;
    logic [63:0] resp_rdata, load_data;
    logic        load_data_valid, misalign, bus_err;

    always #5 clock = ~clock;

    mem_stage_ctrl #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_ls_size(in_ls_size), .in_is_unsigned(in_is_unsigned),
        .in_ls_address(in_ls_address), .in_store_data(in_store_data),
        .flush(flush), .mem_stall(mem_stall),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_is_write(req_is_write), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .load_data(load_data), .load_data_valid(load_data_valid),
        .misalign(misalign), .bus_err(bus_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Observations gathered by run_op over one instruction's lifetime.
    int          o_stall, o_ldv, o_mis, o_be, o_reqcyc, o_acc_cyc, o_be_cyc;
    bit          o_unstable, o_hung;
    logic [63:0] o_addr, o_wdata, o_ld;
    logic [7:0]  o_wmask;
    logic        o_wr;

    function automatic int size_bytes(input logic [3:0] s);
        if ($countones(s) != 1) return 0;
        for (int i = 0; i < 4; i++) if (s[i]) return 1 << i;
        return 0;
    endfunction

    function automatic bit model_bad(input logic [3:0] s, input logic [63:0] a);
        int nb;
        nb = size_bytes(s);
        if (nb == 0) return 1'b1;
        return (int'(a[2:0]) % nb) != 0;
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] rdata, input int nb, input int off, input bit uns);
        logic [63:0] v, mask;
        v = rdata >> (8 * off);
        if (nb >= 8) return v;
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v = v & mask;
        if (!uns && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [7:0] model_wmask(input int nb, input int off);
        int m;
        m = ((1 << nb) - 1) << off;
        return m[7:0];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Presents one op and plays the memory side; rsp_dly<0 means never respond.
    task automatic run_op(input bit ld, input logic [3:0] size, input bit uns, input logic [63:0] addr,
                          input logic [63:0] sdata, input int rdy_dly, input int rsp_dly, input logic [63:0] rdata);
        int rdy_cnt = 0;
        int wait_idx = 0;
        int cyc = 0;
        int post = -1;
        bit acc = 0;
        o_stall = 0; o_ldv = 0; o_mis = 0; o_be = 0; o_reqcyc = 0; o_acc_cyc = -1; o_be_cyc = -1;
        o_unstable = 0; o_addr = 0; o_wdata = 0; o_wmask = 0; o_wr = 0; o_ld = 0;
        in_valid = 1; in_is_load = ld; in_is_store = !ld; in_ls_size = size;
        in_is_unsigned = uns; in_ls_address = addr; in_store_data = sdata;
        while (post < 2 && cyc < 80) begin
            req_ready  = req_valid && (rdy_cnt >= rdy_dly);
            resp_valid = acc && (wait_idx == rsp_dly);
            resp_rdata = rdata;
            #2;
            if (mem_stall) o_stall++;
            if (req_valid) begin
                if (o_reqcyc > 0 && {req_addr, req_wdata, req_wmask, req_is_write} !== {o_addr, o_wdata, o_wmask, o_wr})
                    o_unstable = 1;
                o_addr = req_addr; o_wdata = req_wdata; o_wmask = req_wmask; o_wr = req_is_write;
                o_reqcyc++;
                rdy_cnt++;
                if (req_ready) begin acc = 1; o_acc_cyc = cyc; end
            end
            if (load_data_valid) begin o_ldv++; o_ld = load_data; end
            if (misalign) o_mis++;
            if (bus_err) begin o_be++; o_be_cyc = cyc; end
            if (acc) wait_idx++;
            if (post >= 0) post++;
            else if (!mem_stall) post = 0;
            tick();
            if (post == 0) begin in_valid = 0; in_is_load = 0; in_is_store = 0; end
            cyc++;
        end
        req_ready = 0; resp_valid = 0; in_valid = 0; in_is_load = 0; in_is_store = 0;
        o_hung = (post < 2);
    endtask

    task automatic test_reset();
        reset = 1; in_valid = 0; in_is_load = 0; in_is_store = 0; in_ls_size = 0; in_is_unsigned = 0;
        in_ls_address = 0; in_store_data = 0; flush = 0; req_ready = 0; resp_valid = 0; resp_rdata = 0;
        repeat (3) tick();
        reset = 0;
        #2;
        n_tests++;
        if ({req_valid, req_is_write, load_data_valid, misalign, bus_err, mem_stall} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags got %b exp 000000", {req_valid, req_is_write, load_data_valid, misalign, bus_err, mem_stall});
        end
        n_tests++;
        if ({req_addr, req_wdata, req_wmask, load_data} !== 200'd0) begin
            n_fail++; $display("FAIL reset_data addr=%h wdata=%h wmask=%h ld=%h exp all 0", req_addr, req_wdata, req_wmask, load_data);
        end
        tick();
    endtask

    task automatic test_load_dword();
        run_op(1, 4'b1000, 0, 64'h1000, 64'd0, 0, 3, 64'h8877665544332211);
        n_tests++;
        if (o_addr !== 64'h1000 || o_wmask !== 8'h00 || o_wr !== 1'b0) begin
            n_fail++; $display("FAIL ld_req addr=%h wmask=%h wr=%b exp 1000/00/0", o_addr, o_wmask, o_wr);
        end
        n_tests++;
        if (o_stall !== 5) begin n_fail++; $display("FAIL ld_stall got %0d exp 5", o_stall); end
        n_tests++;
        if (o_ldv !== 1 || o_ld !== 64'h8877665544332211) begin
            n_fail++; $display("FAIL ld_data valid_cnt=%0d data=%h exp 1/8877665544332211", o_ldv, o_ld);
        end
        n_tests++;
        if (o_hung || o_unstable) begin n_fail++; $display("FAIL ld_proto hung=%0d unstable=%0d exp 0/0", o_hung, o_unstable); end
    endtask

    task automatic test_load_byte();
        run_op(1, 4'b0001, 0, 64'h2003, 64'd0, 1, 2, 64'h0000000080000000);
        n_tests++;
        if (o_ldv !== 1 || o_ld !== 64'hFFFFFFFFFFFFFF80) begin
            n_fail++; $display("FAIL lb valid_cnt=%0d data=%h exp 1/ffffffffffffff80", o_ldv, o_ld);
        end
        run_op(1, 4'b0001, 1, 64'h2003, 64'd0, 0, 1, 64'h0000000080000000);
        n_tests++;
        if (o_ldv !== 1 || o_ld !== 64'h80) begin
            n_fail++; $display("FAIL lbu valid_cnt=%0d data=%h exp 1/80", o_ldv, o_ld);
        end
    endtask

    task automatic test_store_half();
        run_op(0, 4'b0010, 0, 64'h3006, 64'hABCD, 0, 2, 64'hFFFF_FFFF_FFFF_FFFF);
        n_tests++;
        if (o_wdata !== 64'hABCD000000000000 || o_wmask !== 8'hC0 || o_wr !== 1'b1 || o_addr !== 64'h3000) begin
            n_fail++; $display("FAIL sh_req wdata=%h wmask=%h wr=%b addr=%h exp abcd000000000000/c0/1/3000", o_wdata, o_wmask, o_wr, o_addr);
        end
        n_tests++;
        if (o_ldv !== 0 || o_stall !== 4) begin n_fail++; $display("FAIL sh_done ldv=%0d stall=%0d exp 0/4", o_ldv, o_stall); end
    endtask

    task automatic test_misalign();
        run_op(1, 4'b0100, 0, 64'h4002, 64'd0, 0, 1, 64'd0);
        n_tests++;
        if (o_mis !== 1 || o_reqcyc !== 0 || o_stall !== 0 || o_ldv !== 0) begin
            n_fail++; $display("FAIL lw_misalign mis=%0d reqcyc=%0d stall=%0d ldv=%0d exp 1/0/0/0", o_mis, o_reqcyc, o_stall, o_ldv);
        end
    endtask

    task automatic test_flush();
        int be = 0;
        int busy = 0;
        // Flush in REQ wins over a simultaneous req_ready.
        in_valid = 1; in_is_load = 1; in_is_store = 0; in_ls_size = 4'b0010; in_ls_address = 64'h7002; in_is_unsigned = 0;
        tick();
        flush = 1; req_ready = 1;
        #2;
        n_tests++;
        if (req_valid !== 1'b1) begin n_fail++; $display("FAIL flush_req_pre req_valid=%b exp 1", req_valid); end
        tick();
        flush = 0; req_ready = 0; in_valid = 0; in_is_load = 0;
        #2;
        n_tests++;
        if (req_valid !== 1'b0 || mem_stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_req req_valid=%b stall=%b exp 0/0", req_valid, mem_stall);
        end
        repeat (12) begin tick(); #2; if (bus_err) be++; if (mem_stall || req_valid) busy++; end
        n_tests++;
        if (be !== 0 || busy !== 0) begin n_fail++; $display("FAIL flush_req_idle bus_err=%0d busy=%0d exp 0/0", be, busy); end
        tick();
        // Flush while waiting: old response must be dropped, new load stalls in DRAIN.
        in_valid = 1; in_is_load = 1; in_ls_size = 4'b1000; in_ls_address = 64'h5000;
        tick();
        req_ready = 1;
        tick();
        req_ready = 0; flush = 1;
        tick();
        flush = 0; in_ls_address = 64'h6008;
        #2;
        n_tests++;
        if (mem_stall !== 1'b1 || req_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_stall stall=%b req_valid=%b exp 1/0", mem_stall, req_valid);
        end
        tick();
        resp_valid = 1; resp_rdata = 64'hDEADBEEF0BADF00D;
        #2;
        n_tests++;
        if (mem_stall !== 1'b1) begin n_fail++; $display("FAIL drain_resp_stall stall=%b exp 1", mem_stall); end
        tick();
        resp_valid = 0;
        run_op(1, 4'b1000, 0, 64'h6008, 64'd0, 1, 2, 64'h0123456789ABCDEF);
        n_tests++;
        if (o_ldv !== 1 || o_ld !== 64'h0123456789ABCDEF || o_addr !== 64'h6008 || o_stall !== 5) begin
            n_fail++; $display("FAIL after_drain ldv=%0d data=%h addr=%h stall=%0d exp 1/0123456789abcdef/6008/5", o_ldv, o_ld, o_addr, o_stall);
        end
    endtask

    task automatic test_timeout();
        run_op(1, 4'b1000, 0, 64'h8000, 64'd0, 0, -1, 64'd0);
        n_tests++;
        if (o_be !== 1 || o_be_cyc - o_acc_cyc !== TO + 1) begin
            n_fail++; $display("FAIL timeout_be count=%0d delay=%0d exp 1/%0d", o_be, o_be_cyc - o_acc_cyc, TO + 1);
        end
        n_tests++;
        if (load_data !== 64'd0 || o_ldv !== 1 || o_stall !== 2 + TO || o_hung) begin
            n_fail++; $display("FAIL timeout_done ld=%h ldv=%0d stall=%0d hung=%0d exp 0/1/%0d/0", load_data, o_ldv, o_stall, o_hung, 2 + TO);
        end
        #2;
        n_tests++;
        if (mem_stall !== 1'b0 || req_valid !== 1'b0) begin
            n_fail++; $display("FAIL timeout_idle stall=%b req_valid=%b exp 0/0", mem_stall, req_valid);
        end
        tick();
        run_op(0, 4'b0001, 0, 64'h8001, 64'h5A, 2, -1, 64'd0);
        n_tests++;
        if (o_be !== 1 || o_ldv !== 0 || o_stall !== 4 + TO) begin
            n_fail++; $display("FAIL timeout_store be=%0d ldv=%0d stall=%0d exp 1/0/%0d", o_be, o_ldv, o_stall, 4 + TO);
        end
    endtask

    task automatic test_reset_mid();
        int be = 0;
        int busy = 0;
        in_valid = 1; in_is_load = 1; in_is_store = 0; in_ls_size = 4'b0100; in_ls_address = 64'h9004;
        tick();
        req_ready = 1;
        tick();
        req_ready = 0; reset = 1; in_valid = 0; in_is_load = 0;
        tick();
        reset = 0;
        repeat (12) begin #2; if (bus_err || load_data_valid) be++; if (mem_stall || req_valid) busy++; tick(); end
        n_tests++;
        if (be !== 0 || busy !== 0) begin n_fail++; $display("FAIL reset_mid pulses=%0d busy=%0d exp 0/0", be, busy); end
    endtask

    task automatic test_random();
        bit ld, uns, bad;
        logic [3:0] size;
        logic [63:0] addr, sdata, rdata;
        int rd, rs, nb, off;
        for (int n = 0; n < 40; n++) begin
            ld = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) size = 4'($urandom);
            else size = 4'(1 << $urandom_range(0, 3));
            nb = size_bytes(size);
            addr = {$urandom, $urandom};
            if (nb != 0 && $urandom_range(0, 3) != 0) addr[2:0] = 3'(($urandom_range(0, 7) / nb) * nb);
            sdata = {$urandom, $urandom};
            rdata = {$urandom, $urandom};
            rd = $urandom_range(0, 3);
            rs = $urandom_range(1, 4);
            off = int'(addr[2:0]);
            bad = model_bad(size, addr);
            run_op(ld, size, uns, addr, sdata, rd, rs, rdata);
            n_tests++;
            if (o_hung || o_be !== 0 || o_mis !== int'(bad)) begin
                n_fail++; $display("FAIL rand[%0d] status hung=%0d be=%0d mis=%0d exp 0/0/%0d", n, o_hung, o_be, o_mis, bad);
            end
            if (bad) begin
                n_tests++;
                if (o_reqcyc !== 0 || o_stall !== 0 || o_ldv !== 0) begin
                    n_fail++; $display("FAIL rand[%0d] bad_op reqcyc=%0d stall=%0d ldv=%0d exp 0/0/0", n, o_reqcyc, o_stall, o_ldv);
                end
            end else begin
                n_tests++;
                if (o_addr !== {addr[63:3], 3'b000} || o_wr !== !ld || o_stall !== 2 + rd + rs || o_unstable) begin
                    n_fail++; $display("FAIL rand[%0d] req addr=%h wr=%b stall=%0d unstable=%0d exp %h/%b/%0d/0",
                                       n, o_addr, o_wr, o_stall, o_unstable, {addr[63:3], 3'b000}, !ld, 2 + rd + rs);
                end
                if (ld) begin
                    n_tests++;
                    if (o_ldv !== 1 || o_ld !== model_load(rdata, nb, off, uns) || o_wmask !== 8'h00) begin
                        n_fail++; $display("FAIL rand[%0d] load ldv=%0d data=%h wmask=%h exp 1/%h/00",
                                           n, o_ldv, o_ld, o_wmask, model_load(rdata, nb, off, uns));
                    end
                end else begin
                    n_tests++;
                    if (o_ldv !== 0 || o_wdata !== (sdata << (8 * off)) || o_wmask !== model_wmask(nb, off)) begin
                        n_fail++; $display("FAIL rand[%0d] store ldv=%0d wdata=%h wmask=%h exp 0/%h/%h",
                                           n, o_ldv, o_wdata, o_wmask, sdata << (8 * off), model_wmask(nb, off));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_dword();
        test_load_byte();
        test_store_half();
        test_misalign();
        test_flush();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
